// File: rtl/muldiv_pkg.sv
// Shared encodings and small arithmetic helpers for the multiply/divide sequencer.
// Pure declarations; no state, no timing of its own.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic c);
    return c ? (32'd0 - x) : x;
  endfunction

  function automatic logic [63:0] ext64(input logic [31:0] x, input logic sgn);
    return {{32{sgn & x[31]}}, x};
  endfunction

endpackage

// File: rtl/muldiv_seq_div_radix2_core.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per step.
// 32 steps after load; the caller holds off step while it is stalled or flushed.
module div_radix2_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        sgn,
  input  logic [31:0] dvd,
  input  logic [31:0] dvs,
  output logic        last,
  output logic [31:0] quo_nxt,
  output logic [31:0] rem_nxt
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt_q;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        restore;

  // The 33-bit partial remainder only lives between shift and subtract; the
  // stored remainder is always below the divisor so 32 bits hold it.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    restore = diff[32] & ~rem_sh[32];
    rem_nxt = restore ? rem_sh[31:0] : diff[31:0];
    quo_nxt = {quo_q[30:0], ~restore};
  end

  assign last = (cnt_q == 5'(DIV_ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= neg_if(dvd, sgn & dvd[31]);
      dvs_q <= neg_if(dvs, sgn & dvs[31]);
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer: 1+MUL_CYC cycles for multiply, 33 for divide, 1 for divide-by-zero.
// busy stalls the pipeline while iterating; cancel aborts without writing HI/LO.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter logic [31:0] DZ_LO   = 32'hFFFF_FFFF,
  parameter int          MUL_CYC = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        hilo_write,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t      state, next_state;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [1:0]  mul_cnt;

  logic        is_mul, op_sgn, accept, mul_last;
  logic        div_load, div_step, div_last;
  logic [31:0] quo_nxt, rem_nxt, q_fix, r_fix;
  logic [63:0] prod;

  always_comb begin
    is_mul = 1'b1;
    op_sgn = 1'b1;
    case (op)
      MD_MULT:  begin is_mul = 1'b1; op_sgn = 1'b1; end
      MD_MULTU: begin is_mul = 1'b1; op_sgn = 1'b0; end
      MD_DIV:   begin is_mul = 1'b0; op_sgn = 1'b1; end
      MD_DIVU:  begin is_mul = 1'b0; op_sgn = 1'b0; end
    endcase
  end

  assign accept   = (state == S_IDLE) & start & ~cancel;
  assign mul_last = (mul_cnt == 2'(MUL_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start && !cancel) begin
          if (is_mul)        next_state = S_MUL;
          else if (b == '0)  next_state = S_DONE;
          else               next_state = S_DIV;
        end
      end
      S_MUL:  if (cancel) next_state = S_IDLE; else if (mul_last) next_state = S_DONE;
      S_DIV:  if (cancel) next_state = S_IDLE; else if (div_last) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
    endcase
  end

  // A flush in DONE still suppresses the write strobe that cycle.
  always_comb begin
    busy       = (state != S_IDLE);
    hilo_write = (state == S_DONE) & ~cancel;
    div_load   = accept & ~is_mul & (b != '0);
    div_step   = (state == S_DIV) & ~cancel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      mul_cnt <= '0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        sgn_q <= op_sgn;
      end
      mul_cnt <= (state == S_MUL) ? mul_cnt + 2'd1 : 2'd0;
    end
  end

  assign prod  = ext64(a_q, sgn_q) * ext64(b_q, sgn_q);
  assign q_fix = neg_if(quo_nxt, sgn_q & (a_q[31] ^ b_q[31]));
  assign r_fix = neg_if(rem_nxt, sgn_q & a_q[31]);

  div_radix2_core u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (div_load),
    .step    (div_step),
    .sgn     (op_sgn),
    .dvd     (a),
    .dvs     (b),
    .last    (div_last),
    .quo_nxt (quo_nxt),
    .rem_nxt (rem_nxt)
  );

  // Results are captured on the edge into DONE so they are visible with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state != S_DONE && next_state == S_DONE) begin
      case (state)
        S_IDLE:  begin hi_out <= a;            lo_out <= DZ_LO;        end
        S_MUL:   begin hi_out <= prod[63:32];  lo_out <= prod[31:0];   end
        S_DIV:   begin hi_out <= r_fix;        lo_out <= q_fix;        end
        default: begin hi_out <= hi_out;       lo_out <= lo_out;       end
      endcase
    end
  end

endmodule
